// File: rtl/ms_ff_sequencer_if.sv
// rtl/ms_ff_sequencer_if.sv - request/grant/status bus between control logic and ms_ff_sequencer
interface ms_ff_sequencer_if;
  logic       req_a;
  logic [1:0] cmd_a;
  logic       req_b;
  logic [1:0] cmd_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic       done;

  // Control-logic side: raises requests, watches grants and status
  modport master (
    output req_a, cmd_a, req_b, cmd_b,
    input  gnt_a, gnt_b, busy, done
  );

  // Sequencer side
  modport slave (
    input  req_a, cmd_a, req_b, cmd_b,
    output gnt_a, gnt_b, busy, done
  );
endinterface

// File: rtl/ms_ff_sequencer.sv
// rtl/ms_ff_sequencer.sv - two-requester phase sequencer for a master-slave SR flip-flop (option: MS_FF_SEQ_READBACK_EN)
module ms_ff_sequencer #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic             clock,
  input  logic             reset,
  ms_ff_sequencer_if.slave bus,
  input  logic             q_fb,
  output logic             S,
  output logic             R,
  output logic             C_master,
  output logic             C_slave,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_MASTER, ST_GAP, ST_SLAVE, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_HOLD, OP_SET, OP_RESET
  } op_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;       // 1: B is favoured when both request
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       cm_q, cm_d;
  logic       cs_q, cs_d;
  logic       err_q, err_d;

  logic       accept;
  logic       pick_b;
  logic [1:0] win_cmd;
  op_e        win_op;
  logic       drive_sr;

  // Pick the winner and resolve its command; toggle looks at the current slave Q
  always_comb begin
    accept  = bus.req_a | bus.req_b;
    pick_b  = bus.req_b & (~bus.req_a | ptr_q);
    win_cmd = pick_b ? bus.cmd_b : bus.cmd_a;
    win_op  = OP_HOLD;
    case (win_cmd)
      2'b01:   win_op = OP_SET;
      2'b10:   win_op = OP_RESET;
      2'b11:   win_op = q_fb ? OP_RESET : OP_SET;
      default: win_op = OP_HOLD;
    endcase
  end

  // Phase FSM: each timed state loads its length-1 on entry and leaves at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = win_op;
          ptr_d   = ~pick_b;
          gnt_a_d = ~pick_b;
          gnt_b_d = pick_b;
          if (win_op == OP_HOLD) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_MASTER;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_MASTER: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SLAVE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SLAVE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state so they line up with it
  always_comb begin
    drive_sr = (state_d == ST_SETUP) || (state_d == ST_MASTER) || (state_d == ST_GAP);
    s_d      = drive_sr && (op_d == OP_SET);
    r_d      = drive_sr && (op_d == OP_RESET);
    cm_d     = (state_d == ST_MASTER);
    cs_d     = (state_d == ST_SLAVE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
`ifdef MS_FF_SEQ_READBACK_EN
    err_d    = err_q | ((state_q == ST_DONE) &&
                        (((op_q == OP_SET) && !q_fb) || ((op_q == OP_RESET) && q_fb)));
`else
    err_d    = 1'b0;
`endif
  end

  // State and output registers; reset drops every drive on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      cm_q    <= 1'b0;
      cs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cm_q    <= cm_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign S         = s_q;
  assign R         = r_q;
  assign C_master  = cm_q;
  assign C_slave   = cs_q;
  assign err       = err_q;

endmodule
